qspi_block_proc: RTL and testbench

- Parametrised successor to the fixed 16-word "+5" RAM processor.
- On a start pulse, reads LEN words from a source region of the shared single-port RAM into an internal buffer, transforms each word with a selectable operation and operand, then writes the results to a destination region.
- Sits between the QSPI-loaded buffer RAM and the rest of the data path.
- Signals completion with busy/done.

---
 rtl/qspi_block_proc_if.sv | 32 +++
 rtl/qspi_block_proc.sv | 199 +++++++++++++++++++
 tb/tb_qspi_block_proc.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_block_proc_if.sv
// Job-control and RAM-bus signals of the block processor.
// The block side uses the slave modport. The controller/RAM side uses master.
interface qspi_block_proc_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 5
);
  // job control
  logic                  start;
  logic [LEN_WIDTH-1:0]  len;
  logic [ADDR_WIDTH-1:0] src_base;
  logic [ADDR_WIDTH-1:0] dst_base;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] operand;
  logic                  busy;
  logic                  done;
  // RAM port
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  wen;

  modport slave (
    input  start, len, src_base, dst_base, mode, operand, data_in,
    output busy, done, addr, data_out, wen
  );

  modport master (
    output start, len, src_base, dst_base, mode, operand, data_in,
    input  busy, done, addr, data_out, wen
  );
endinterface

// File: rtl/qspi_block_proc.sv
// Block processor: reads up to DEPTH words from a source region of a
// single-port RAM into a buffer, transforms each word, then writes the
// results to a destination region. All reads finish before the first write,
// so in-place and overlapping jobs are safe.
module qspi_block_proc #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned LEN_WIDTH  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  qspi_block_proc_if.slave    bus
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] operand_q, operand_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  wen_q, wen_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Read-return tracking: stage 1 = address just issued, stage 2 = data on data_in now.
  logic                  rd1_v_q, rd1_v_d, rd2_v_q;
  logic [IdxW-1:0]       rd1_idx_q, rd1_idx_d, rd2_idx_q;

  logic [DATA_WIDTH-1:0] buf_q [DEPTH];

  logic [LEN_WIDTH-1:0]  len_eff;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] rd_result;
  logic [DATA_WIDTH-1:0] wr_data;

  assign len_eff = (bus.len > LEN_WIDTH'(DEPTH)) ? LEN_WIDTH'(DEPTH) : bus.len;

  // Transform the word currently returned by the RAM.
  always_comb begin
    sum       = {1'b0, bus.data_in} + {1'b0, operand_q};
    diff      = {1'b0, bus.data_in} - {1'b0, operand_q};
    rd_result = bus.data_in;
    unique case (mode_q)
      2'd0: rd_result = sum[DATA_WIDTH-1:0];
      2'd1: rd_result = sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
      2'd2: rd_result = diff[DATA_WIDTH] ? '0 : diff[DATA_WIDTH-1:0];
      2'd3: rd_result = bus.data_in ^ operand_q;
    endcase
  end

  // With a single-word job the only capture lands on the same edge as the
  // write, so forward the freshly transformed word instead of the buffer.
  always_comb begin
    if (rd2_v_q && (rd2_idx_q == idx_q[IdxW-1:0])) begin
      wr_data = rd_result;
    end else begin
      wr_data = buf_q[idx_q[IdxW-1:0]];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    src_d      = src_q;
    dst_d      = dst_q;
    mode_d     = mode_q;
    operand_d  = operand_q;
    addr_d     = addr_q;
    data_out_d = data_out_q;
    wen_d      = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd1_v_d    = 1'b0;
    rd1_idx_d  = rd1_idx_q;

    unique case (state_q)
      StIdle: begin
        addr_d     = '0;
        data_out_d = '0;
        busy_d     = 1'b0;
        if (bus.start) begin
          len_d     = len_eff;
          src_d     = bus.src_base;
          dst_d     = bus.dst_base;
          mode_d    = bus.mode;
          operand_d = bus.operand;
          if (len_eff == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d   = StRead;
            busy_d    = 1'b1;
            addr_d    = bus.src_base;
            rd1_v_d   = 1'b1;
            rd1_idx_d = '0;
            idx_d     = LEN_WIDTH'(1);
          end
        end
      end
      StRead: begin
        if (idx_q < len_q) begin
          addr_d    = src_q + ADDR_WIDTH'(idx_q);
          rd1_v_d   = 1'b1;
          rd1_idx_d = idx_q[IdxW-1:0];
          idx_d     = idx_q + 1'b1;
        end else begin
          // one idle edge lets the last read return before writing starts
          state_d = StWrite;
          idx_d   = '0;
        end
      end
      StWrite: begin
        if (idx_q < len_q) begin
          wen_d      = 1'b1;
          addr_d     = dst_q + ADDR_WIDTH'(idx_q);
          data_out_d = wr_data;
          idx_d      = idx_q + 1'b1;
        end else begin
          state_d    = StDone;
          addr_d     = '0;
          data_out_d = '0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end
      end
      StDone: begin
        state_d    = StIdle;
        addr_d     = '0;
        data_out_d = '0;
        busy_d     = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, configuration and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      len_q      <= '0;
      idx_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      mode_q     <= '0;
      operand_q  <= '0;
      addr_q     <= '0;
      data_out_q <= '0;
      wen_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd1_v_q    <= 1'b0;
      rd1_idx_q  <= '0;
      rd2_v_q    <= 1'b0;
      rd2_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      mode_q     <= mode_d;
      operand_q  <= operand_d;
      addr_q     <= addr_d;
      data_out_q <= data_out_d;
      wen_q      <= wen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd1_v_q    <= rd1_v_d;
      rd1_idx_q  <= rd1_idx_d;
      rd2_v_q    <= rd1_v_q;
      rd2_idx_q  <= rd1_idx_q;
    end
  end

  // Capture transformed read data; buffer contents need no reset.
  always_ff @(posedge clk) begin
    if (rd2_v_q) begin
      buf_q[rd2_idx_q] <= rd_result;
    end
  end

  assign bus.addr     = addr_q;
  assign bus.data_out = data_out_q;
  assign bus.wen      = wen_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_qspi_block_proc.sv
// Bench for qspi_block_proc: a synchronous-read RAM model, a job-level
// reference model, per-cycle checks of the RAM bus and handshake, and
// directed plus randomized jobs.
module tb_qspi_block_proc;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  qspi_block_proc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bif ();

  qspi_block_proc #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .LEN_WIDTH (LW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  // RAM with 1-cycle read latency, plus a bench-side load port.
  logic [7:0] ram [256];
  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;

  always @(posedge clk) begin
    bif.data_in <= ram[bif.addr];
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (bif.wen) ram[bif.addr] <= bif.data_out;
  end

  logic [7:0] model [256];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_op(input int mode, input int x, input int op);
    int r;
    case (mode)
      0:       r = (x + op) % 256;
      1:       r = (x + op > 255) ? 255 : x + op;
      2:       r = (x < op) ? 0 : x - op;
      default: r = x ^ op;
    endcase
    return r;
  endfunction

  task automatic load(input int a, input int d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = a[7:0];
    ld_data = d[7:0];
    model[a % 256] = d[7:0];
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic compare_mem(input string tag);
    for (int a = 0; a < 256; a++) begin
      check($sformatf("%s mem[%0h]", tag, a), 32'(ram[a]), 32'(model[a]));
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, 32'(bif.busy), 0);
    check({tag, " done"}, 32'(bif.done), 0);
    check({tag, " wen"}, 32'(bif.wen), 0);
    check({tag, " addr"}, 32'(bif.addr), 0);
    check({tag, " dout"}, 32'(bif.data_out), 0);
  endtask

  // Run one job and check every cycle from the start edge to the return to idle.
  task automatic run_job(input string tag, input int len, input int src, input int dst,
                         input int mode, input int op, input bit spam);
    int l;
    int d;
    int exp_v [DEPTH];
    l = (len > DEPTH) ? DEPTH : len;
    for (int i = 0; i < l; i++) exp_v[i] = ref_op(mode, int'(model[(src + i) % 256]), op);
    d = (l == 0) ? 0 : 2 * l + 1;

    @(negedge clk);
    bif.start    = 1'b1;
    bif.len      = LW'(len);
    bif.src_base = AW'(src);
    bif.dst_base = AW'(dst);
    bif.mode     = 2'(mode);
    bif.operand  = DW'(op);
    @(posedge clk);
    #1;
    if (!spam) bif.start = 1'b0;
    // configuration must have been latched at the start edge
    bif.len      = LW'($urandom);
    bif.src_base = AW'($urandom);
    bif.dst_base = AW'($urandom);
    bif.mode     = 2'($urandom);
    bif.operand  = DW'($urandom);

    for (int n = 0; n <= d; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (n == d) begin
        check($sformatf("%s done@%0d", tag, n), 32'(bif.done), 1);
        check($sformatf("%s busy@done", tag), 32'(bif.busy), 0);
        check($sformatf("%s wen@done", tag), 32'(bif.wen), 0);
        check($sformatf("%s addr@done", tag), 32'(bif.addr), 0);
        check($sformatf("%s dout@done", tag), 32'(bif.data_out), 0);
      end else begin
        check($sformatf("%s done@%0d", tag, n), 32'(bif.done), 0);
        check($sformatf("%s busy@%0d", tag, n), 32'(bif.busy), 1);
        if (n < l) begin
          check($sformatf("%s wen@%0d", tag, n), 32'(bif.wen), 0);
          check($sformatf("%s raddr@%0d", tag, n), 32'(bif.addr), (src + n) % 256);
        end else if (n == l) begin
          check($sformatf("%s wen@%0d", tag, n), 32'(bif.wen), 0);
        end else begin
          check($sformatf("%s wen@%0d", tag, n), 32'(bif.wen), 1);
          check($sformatf("%s waddr@%0d", tag, n), 32'(bif.addr), (dst + n - l - 1) % 256);
          check($sformatf("%s wdata@%0d", tag, n), 32'(bif.data_out), exp_v[n - l - 1]);
        end
      end
    end
    bif.start = 1'b0;

    @(posedge clk);
    #1;
    check_idle({tag, " post"});
    if (spam) begin
      repeat (3) begin
        @(posedge clk);
        #1;
        check({tag, " no rerun busy"}, 32'(bif.busy), 0);
        check({tag, " no rerun wen"}, 32'(bif.wen), 0);
      end
    end

    for (int i = 0; i < l; i++) model[(dst + i) % 256] = 8'(exp_v[i]);
    compare_mem(tag);
  endtask

  initial begin
    ld_en        = 1'b0;
    ld_addr      = '0;
    ld_data      = '0;
    bif.start    = 1'b0;
    bif.len      = '0;
    bif.src_base = '0;
    bif.dst_base = '0;
    bif.mode     = '0;
    bif.operand  = '0;
    rst_n        = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_idle("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < 256; a++) load(a, int'($urandom_range(0, 255)));

    // legacy +5 job
    for (int a = 0; a < 16; a++) load(a, a);
    run_job("legacy", 16, 8'h00, 8'h10, 0, 5, 1'b0);
    for (int a = 0; a < 16; a++) check("legacy val", 32'(ram[8'h10 + a]), 32'(a + 5));

    // saturating add then saturating subtract on the original words
    load(8'h20, 8'hF0); load(8'h21, 8'hFB); load(8'h22, 8'hFC); load(8'h23, 8'h10);
    run_job("addsat", 4, 8'h20, 8'h20, 1, 4, 1'b0);
    check("addsat w1", 32'(ram[8'h21]), 32'hFF);
    load(8'h20, 8'hF0); load(8'h21, 8'hFB); load(8'h22, 8'hFC); load(8'h23, 8'h10);
    run_job("subsat", 4, 8'h20, 8'h20, 2, 8'h11, 1'b0);
    check("subsat w3", 32'(ram[8'h23]), 32'h00);

    // address wrap with XOR
    run_job("wrapxor", 4, 8'hFE, 8'h7E, 3, 8'hA5, 1'b0);

    // length boundaries
    run_job("len0", 0, 8'h30, 8'h40, 0, 1, 1'b0);
    run_job("len31", 31, 8'h50, 8'h90, 0, 3, 1'b0);
    run_job("len1", 1, 8'hC0, 8'hC8, 1, 8'h80, 1'b0);

    // start held high for a whole job
    run_job("spam", 8, 8'h60, 8'h68, 3, 8'h3C, 1'b1);

    // reset during the write phase
    @(negedge clk);
    bif.start    = 1'b1;
    bif.len      = LW'(8);
    bif.src_base = 8'hA0;
    bif.dst_base = 8'hB0;
    bif.mode     = 2'd0;
    bif.operand  = 8'h01;
    @(posedge clk);
    #1 bif.start = 1'b0;
    repeat (8 + 3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_idle("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // partial writes stay in RAM; take them as the new reference contents
    for (int a = 0; a < 256; a++) model[a] = ram[a];
    @(posedge clk);
    #1;
    check_idle("after rst");
    run_job("post rst", 8, 8'hA0, 8'hB0, 0, 8'h01, 1'b0);

    // randomized jobs
    for (int j = 0; j < 20; j++) begin
      run_job($sformatf("rand%0d", j), int'($urandom_range(0, 31)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
